// File: rtl/inst_mem_loader.sv
// Streams big-endian bytes into 32-bit words written to instruction memory from address 0, then checks a trailing XOR byte.
// Word k is written one cycle after its 4th byte. byte_valid gaps stall indefinitely. Bytes are refused while a word is being written.
module inst_mem_loader #(
  parameter int ADDR_W = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] word_cnt_inc;
  logic [1:0]        byte_cnt;
  logic [31:0]       asm_word;
  logic [7:0]        xor_sum;
  logic              err_q;

  assign word_cnt_inc = word_cnt + ADDR_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_wr_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_reset  = 1'b1;
    error      = err_q;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_words != '0) ? RECV : CHECK;
      end
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && byte_cnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        busy      = 1'b1;
        state_nxt = (word_cnt_inc == target) ? CHECK : RECV;
      end
      CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        cpu_reset = err_q;
        if (start) state_nxt = (num_words != '0) ? RECV : CHECK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr/mem_data are loaded as the 4th byte lands, so they are valid for the whole WRITE cycle and hold afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target   <= '0;
      word_cnt <= '0;
      byte_cnt <= 2'd0;
      asm_word <= 32'd0;
      xor_sum  <= 8'd0;
      err_q    <= 1'b0;
      mem_addr <= '0;
      mem_data <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            target   <= num_words;
            word_cnt <= '0;
            byte_cnt <= 2'd0;
            asm_word <= 32'd0;
            xor_sum  <= 8'd0;
            err_q    <= 1'b0;
          end
        end
        RECV: begin
          if (byte_valid) begin
            asm_word <= {asm_word[23:0], byte_in};
            xor_sum  <= xor_sum ^ byte_in;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_addr <= word_cnt;
              mem_data <= {asm_word[23:0], byte_in};
            end
          end
        end
        WRITE: word_cnt <= word_cnt_inc;
        CHECK: begin
          if (byte_valid) err_q <= (byte_in != xor_sum);
        end
        default: ;
      endcase
    end
  end

endmodule
